// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader: FSM encoding,
// default widths and the per-word bit-count helper.
package ccff_loader_pkg;

  localparam int unsigned WORD_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 20;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } ccff_state_e;

  function automatic int unsigned min_bits(input int unsigned bits_left,
                                           input int unsigned word_w);
    return (bits_left < word_w) ? bits_left : word_w;
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream (valid/ready) feeding the configuration-chain loader.
interface ccff_chain_loader_if
  import ccff_loader_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF
);

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/ccff_chain_loader_rb_packer.sv
// Readback deserializer: packs chain-tail bits MSB-first into words and
// flushes a left-aligned partial word at the end of a load.
module ccff_rb_packer
  import ccff_loader_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              sample_en,
  input  logic              bit_in,
  input  logic              flush,
  input  logic              clr,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid
);

  localparam int unsigned CW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] acc_q, acc_d, acc_new;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_new;
  logic              valid_q, valid_d;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge prog_clk) begin
    acc_q <= acc_d;
  end

  // The last tail bit and the flush arrive together, so the bit is folded in first.
  always_comb begin
    acc_new = acc_q;
    cnt_new = cnt_q;
    if (sample_en) begin
      acc_new = {acc_q[WORD_W-2:0], bit_in};
      cnt_new = cnt_q + CW'(1);
    end
    acc_d   = acc_new;
    cnt_d   = cnt_new;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_new == CW'(WORD_W)) begin
      word_d  = acc_new;
      valid_d = 1'b1;
      cnt_d   = '0;
    end else if (flush && (cnt_new != '0)) begin
      word_d  = acc_new << (CW'(WORD_W) - cnt_new);
      valid_d = 1'b1;
      cnt_d   = '0;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words MSB-first onto the fabric ccff chain with a per-bit clock enable.
// Optional tail readback packer is built when CCFF_READBACK_EN is defined.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                 prog_clk,
  input  logic                 pReset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     cfg_bits,
  ccff_chain_loader_if.slave   s_if,
  output logic                 ccff_head,
  output logic                 ccff_clk_en,
  input  logic                 ccff_tail,
  output logic [WORD_W-1:0]    rb_data,
  output logic                 rb_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned IDX_W = $clog2(WORD_W + 1);

  ccff_state_e       state_q, state_d;
  logic [CNT_W-1:0]  bits_left_q, bits_left_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              head_q, head_d;
  logic              clk_en_q, clk_en_d;
  logic              handshake;

  assign handshake = s_if.s_valid && s_if.s_ready;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= IDLE;
      bits_left_q <= '0;
      bit_idx_q   <= '0;
      head_q      <= 1'b0;
      clk_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      bit_idx_q   <= bit_idx_d;
      head_q      <= head_d;
      clk_en_q    <= clk_en_d;
    end
  end

  always_ff @(posedge prog_clk) begin
    sreg_q <= sreg_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = (cfg_bits == '0) ? DONE : FETCH;
        FETCH:   if (handshake) state_d = SHIFT;
        SHIFT:   if (bit_idx_q == IDX_W'(1))
                   state_d = (bits_left_q == CNT_W'(1)) ? DONE : FETCH;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // head/clk_en are loaded one cycle ahead so the flop outputs line up with
  // the SHIFT cycle that clocks each bit into the chain.
  always_comb begin
    bits_left_d = bits_left_q;
    bit_idx_d   = bit_idx_q;
    sreg_d      = sreg_q;
    head_d      = head_q;
    clk_en_d    = 1'b0;
    if (!abort) begin
      case (state_q)
        IDLE: if (start) bits_left_d = cfg_bits;
        FETCH: if (handshake) begin
          bit_idx_d = IDX_W'(min_bits(32'(bits_left_q), WORD_W));
          head_d    = s_if.s_data[WORD_W-1];
          sreg_d    = s_if.s_data << 1;
          clk_en_d  = 1'b1;
        end
        SHIFT: begin
          bits_left_d = bits_left_q - CNT_W'(1);
          bit_idx_d   = bit_idx_q - IDX_W'(1);
          if (bit_idx_q != IDX_W'(1)) begin
            head_d   = sreg_q[WORD_W-1];
            sreg_d   = sreg_q << 1;
            clk_en_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_if.s_ready = (state_q == FETCH) && !abort;
    busy         = (state_q != IDLE);
    done         = (state_q == DONE);
  end

  assign ccff_head   = head_q;
  assign ccff_clk_en = clk_en_q;

`ifdef CCFF_READBACK_EN
  logic rb_flush;
  logic rb_clr;

  assign rb_flush = (state_q == SHIFT) && (state_d == DONE);
  assign rb_clr   = abort || ((state_q == IDLE) && start);

  ccff_rb_packer #(
    .WORD_W (WORD_W)
  ) u_rb_packer (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .sample_en  (clk_en_q),
    .bit_in     (ccff_tail),
    .flush      (rb_flush),
    .clr        (rb_clr),
    .word_out   (rb_data),
    .word_valid (rb_valid)
  );
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign rb_data     = '0;
  assign rb_valid    = 1'b0;
`endif

endmodule
